// File: rtl/sine_width_dds_pkg.sv
// Shared constants, quadrant encoding and the constant function that fills the
// quarter-wave sine table at elaboration time.
package sine_pkg;

    localparam int unsigned PERIOD_DEF = 1000;
    localparam int unsigned GUARD_DEF  = 4;
    localparam int unsigned LUT_AW_DEF = 8;
    localparam int unsigned HALF_DEF   = PERIOD_DEF / 2;
    localparam int unsigned AMP_DEF    = HALF_DEF - GUARD_DEF;

    // Quadrant taken from the top two phase bits.
    typedef enum logic [1:0] {
        QUAD_POS_RISE = 2'd0,
        QUAD_POS_FALL = 2'd1,
        QUAD_NEG_FALL = 2'd2,
        QUAD_NEG_RISE = 2'd3
    } quadrant_e;

    // pi in Q30 fixed point; integer maths keeps the table identical in every tool.
    localparam longint PI_Q30 = 64'sd3373259426;

    // round(amp * sin(pi/2 * (2i+1) / 2^(aw+1))), Taylor series in Q30.
    function automatic logic [31:0] quarter_sine(input int unsigned i,
                                                 input int unsigned amp,
                                                 input int unsigned aw);
        longint x;
        longint term;
        longint sum;
        x    = (PI_Q30 * longint'(2 * i + 1)) >>> (aw + 2);
        term = x;
        sum  = x;
        for (int k = 1; k < 10; k++) begin
            term = -((((term * x) >>> 30) * x) >>> 30) / longint'((2 * k) * (2 * k + 1));
            sum  = sum + term;
        end
        return 32'((longint'(amp) * sum + (64'sd1 <<< 29)) >>> 30);
    endfunction

endpackage

// File: rtl/sine_quarter_rom.sv
// Synchronous quarter-wave sine ROM; one registered read per cycle, no reset so
// it maps onto block RAM.
module sine_quarter_rom
    import sine_pkg::*;
#(
    parameter int unsigned AW  = LUT_AW_DEF,
    parameter int unsigned AMP = AMP_DEF
) (
    input  logic          clk,
    input  logic [AW-1:0] addr_i,
    output logic [31:0]   data_o
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [31:0] rom_mem [DEPTH];
    logic [31:0] data_q;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
        localparam logic [31:0] WORD = quarter_sine(gi, AMP, AW);
        assign rom_mem[gi] = WORD;
    end

    always_ff @(posedge clk) begin
        data_q <= rom_mem[addr_i];
    end

    assign data_o = data_q;

endmodule

// File: rtl/sine_width_dds.sv
// Per-tick phase accumulator -> quarter-wave lookup -> offset-binary PWM width.
// Three registers deep: phase, ROM read + quadrant, width.
module sine_width_dds
    import sine_pkg::*;
#(
    parameter int unsigned PERIOD = PERIOD_DEF,
    parameter int unsigned GUARD  = GUARD_DEF,
    parameter int unsigned LUT_AW = LUT_AW_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic [31:0] freq_word,
    input  logic        phase_clr,
    output logic [31:0] width,
    output logic        width_valid
);

    localparam int unsigned HALF   = PERIOD / 2;
    localparam int unsigned AMP    = HALF - GUARD;
    localparam logic [31:0] HALF_W = 32'(HALF);

    logic [31:0]       phase_q;
    logic [31:0]       phase_d;
    logic              v0_q;
    quadrant_e         quad0;
    logic [LUT_AW-1:0] idx0;
    logic [LUT_AW-1:0] rom_addr;
    logic [31:0]       rom_data;
    quadrant_e         quad1_q;
    logic              v1_q;
    logic [31:0]       width_q;
    logic [31:0]       width_d;
    logic              wv_q;

    always_comb begin
        phase_d = phase_q;
        if (tick) begin
            phase_d = phase_clr ? 32'd0 : phase_q + freq_word;
        end
    end

    assign quad0 = quadrant_e'(phase_q[31:30]);
    assign idx0  = phase_q[29 -: LUT_AW];

    // Odd quadrants read the table backwards; the half-sample offset makes ~idx exact.
    always_comb begin
        rom_addr = idx0;
        if (quad0 == QUAD_POS_FALL || quad0 == QUAD_NEG_RISE) begin
            rom_addr = ~idx0;
        end
    end

    sine_quarter_rom #(
        .AW  (LUT_AW),
        .AMP (AMP)
    ) u_rom (
        .clk    (clk),
        .addr_i (rom_addr),
        .data_o (rom_data)
    );

    always_comb begin
        width_d = HALF_W + rom_data;
        if (quad1_q == QUAD_NEG_FALL || quad1_q == QUAD_NEG_RISE) begin
            width_d = HALF_W - rom_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= 32'd0;
            v0_q    <= 1'b0;
            quad1_q <= QUAD_POS_RISE;
            v1_q    <= 1'b0;
            width_q <= HALF_W;
            wv_q    <= 1'b0;
        end else begin
            phase_q <= phase_d;
            v0_q    <= tick;
            quad1_q <= quad0;
            v1_q    <= v0_q;
            wv_q    <= v1_q;
            if (v1_q) begin
                width_q <= width_d;
            end
        end
    end

    assign width       = width_q;
    assign width_valid = wv_q;

endmodule

// File: tb/tb_sine_width_dds.sv
// Directed bench for sine_width_dds: expected widths are hand-derived from
// s(0)=2, s(1)=5, s(255)=496 with HALF=500.
module tb_sine_width_dds;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick = 1'b0;
    logic [31:0] freq_word = 32'd0;
    logic        phase_clr = 1'b0;
    logic [31:0] width;
    logic        width_valid;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sine_width_dds #(
        .PERIOD (1000),
        .GUARD  (4),
        .LUT_AW (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .freq_word   (freq_word),
        .phase_clr   (phase_clr),
        .width       (width),
        .width_valid (width_valid)
    );

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; tick = 1'b0; phase_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // One isolated tick; checks latency, value and single-cycle pulse.
    task automatic single_tick(input logic [31:0] fw, input logic clr,
                               input int exp_w, input string name);
        int lat;
        bit got;
        @(posedge clk); #1;
        tick = 1'b1; freq_word = fw; phase_clr = clr;
        @(posedge clk); #1;
        tick = 1'b0; phase_clr = 1'b0;
        lat = 0; got = 1'b0;
        for (int c = 1; c <= 6 && !got; c++) begin
            @(negedge clk);
            if (width_valid === 1'b1) begin
                got = 1'b1;
                lat = c;
            end
        end
        $display("  tick fw=%08h clr=%0d -> width=%0d latency=%0d (%s)", fw, clr, width, lat, name);
        n_vec++;
        if (lat !== 3) begin
            n_err++;
            $display("FAIL %s_latency: got %0d cycles, expected 3", name, lat);
        end
        n_vec++;
        if (width !== 32'(exp_w)) begin
            n_err++;
            $display("FAIL %s_width: got %0d, expected %0d", name, width, exp_w);
        end
        @(negedge clk);
        n_vec++;
        if (width_valid !== 1'b0) begin
            n_err++;
            $display("FAIL %s_pulse: width_valid=%b one cycle later, expected 0", name, width_valid);
        end
    endtask

    task automatic test_reset();
        int pulses;
        rst = 1'b1;
        freq_word = 32'h4000_0000;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            tick = c[0];
            @(negedge clk);
            n_vec++;
            if (width_valid !== 1'b0) begin
                n_err++;
                $display("FAIL reset_valid: cycle %0d width_valid=%b, expected 0", c, width_valid);
            end
            n_vec++;
            if (width !== 32'd500) begin
                n_err++;
                $display("FAIL reset_width: cycle %0d width=%0d, expected 500", c, width);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0; tick = 1'b0;
        pulses = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (width_valid !== 1'b0) pulses++;
        end
        $display("  reset released, stray pulses=%0d", pulses);
        n_vec++;
        if (pulses != 0) begin
            n_err++;
            $display("FAIL reset_ticks_ignored: got %0d pulses, expected 0", pulses);
        end
        single_tick(32'h4000_0000, 1'b0, 996, "first_after_reset");
    endtask

    task automatic test_quadrants();
        do_reset();
        single_tick(32'h4000_0000, 1'b0, 996, "quad_q1");
        single_tick(32'h4000_0000, 1'b0, 498, "quad_q2");
        single_tick(32'h4000_0000, 1'b0, 4,   "quad_q3");
        single_tick(32'h4000_0000, 1'b0, 502, "quad_q0");
    endtask

    task automatic test_full_cycle();
        int cnt, first_w, last_w, max_w, min_w, bad;
        do_reset();
        single_tick(32'h0040_0000, 1'b0, 505, "fine_step");
        do_reset();
        freq_word = 32'h0040_0000;
        cnt = 0; first_w = 0; last_w = 0; max_w = 0; min_w = 1000; bad = 0;
        for (int c = 0; c < 1028; c++) begin
            @(posedge clk); #1;
            tick = (c < 1024);
            @(negedge clk);
            if (width_valid === 1'b1) begin
                cnt++;
                $display("  sweep result %0d width=%0d", cnt, width);
                if ($isunknown(width) || width < 32'd4 || width > 32'd996) bad++;
                if (cnt == 1) first_w = int'(width);
                last_w = int'(width);
                if (int'(width) > max_w) max_w = int'(width);
                if (int'(width) < min_w) min_w = int'(width);
            end
        end
        tick = 1'b0;
        n_vec++;
        if (cnt != 1024) begin n_err++; $display("FAIL sweep_count: got %0d, expected 1024", cnt); end
        n_vec++;
        if (first_w != 505) begin n_err++; $display("FAIL sweep_first: got %0d, expected 505", first_w); end
        n_vec++;
        if (last_w != 502) begin n_err++; $display("FAIL sweep_last: got %0d, expected 502", last_w); end
        n_vec++;
        if (max_w != 996) begin n_err++; $display("FAIL sweep_max: got %0d, expected 996", max_w); end
        n_vec++;
        if (min_w != 4) begin n_err++; $display("FAIL sweep_min: got %0d, expected 4", min_w); end
        n_vec++;
        if (bad != 0) begin n_err++; $display("FAIL sweep_range: got %0d bad, expected 0", bad); end
    endtask

    task automatic test_wrap();
        do_reset();
        single_tick(32'hFFFF_FFFF, 1'b0, 498, "wrap_ffffffff");
        single_tick(32'hFFFF_FFFF, 1'b0, 498, "wrap_fffffffe");
        do_reset();
        single_tick(32'h4000_0000, 1'b0, 996, "wrap_pre");
        single_tick(32'hFFFF_FFFF, 1'b0, 996, "wrap_3fffffff");
    endtask

    task automatic test_phase_clr();
        int pulses;
        do_reset();
        single_tick(32'h4000_0000, 1'b0, 996, "clr_pre");
        single_tick(32'h4000_0000, 1'b1, 502, "clr_on_tick");
        single_tick(32'h4000_0000, 1'b0, 996, "clr_post");
        @(posedge clk); #1;
        phase_clr = 1'b1;
        pulses = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (width_valid !== 1'b0) pulses++;
        end
        @(posedge clk); #1;
        phase_clr = 1'b0;
        $display("  phase_clr held without tick, pulses=%0d width=%0d", pulses, width);
        n_vec++;
        if (pulses != 0) begin n_err++; $display("FAIL clr_no_tick_pulse: got %0d, expected 0", pulses); end
        n_vec++;
        if (width !== 32'd996) begin n_err++; $display("FAIL clr_no_tick_width: got %0d, expected 996", width); end
        single_tick(32'h4000_0000, 1'b0, 498, "clr_no_effect");
    endtask

    task automatic test_zero_freq();
        single_tick(32'd0, 1'b0, 498, "zero_freq_a");
        single_tick(32'd0, 1'b0, 498, "zero_freq_b");
    endtask

    task automatic test_back_to_back();
        int exp_w [4];
        int k, first_c;
        exp_w = '{996, 498, 4, 502};
        do_reset();
        freq_word = 32'h4000_0000;
        k = 0; first_c = -1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            tick = (c < 4);
            @(negedge clk);
            if (width_valid === 1'b1) begin
                $display("  b2b result %0d at cycle %0d width=%0d", k, c, width);
                if (first_c < 0) first_c = c;
                if (k < 4) begin
                    n_vec++;
                    if (width !== 32'(exp_w[k])) begin
                        n_err++;
                        $display("FAIL b2b_width%0d: got %0d, expected %0d", k, width, exp_w[k]);
                    end
                end
                k++;
            end
        end
        tick = 1'b0;
        n_vec++;
        if (k != 4) begin n_err++; $display("FAIL b2b_count: got %0d, expected 4", k); end
        n_vec++;
        if (first_c != 3) begin n_err++; $display("FAIL b2b_latency: first at %0d, expected 3", first_c); end
    endtask

    task automatic test_reset_mid();
        int pulses, pulse_w;
        do_reset();
        freq_word = 32'h4000_0000;
        pulses = 0; pulse_w = -1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            tick = (c < 3);
            rst  = (c == 3 || c == 4);
            @(negedge clk);
            if (width_valid === 1'b1) begin
                pulses++;
                pulse_w = int'(width);
                $display("  mid-reset result at cycle %0d width=%0d", c, width);
            end
        end
        n_vec++;
        if (pulses != 1) begin n_err++; $display("FAIL midrst_pulses: got %0d, expected 1", pulses); end
        n_vec++;
        if (pulse_w != 996) begin n_err++; $display("FAIL midrst_first: got %0d, expected 996", pulse_w); end
        n_vec++;
        if (width !== 32'd500) begin n_err++; $display("FAIL midrst_width: got %0d, expected 500", width); end
    endtask

    initial begin
        test_reset();
        test_quadrants();
        test_full_cycle();
        test_wrap();
        test_phase_clr();
        test_zero_freq();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
